// File: rtl/wfg_drive_pat_wb_regbank.sv
// wfg_drive_pat_wb_regbank
// Wishbone register bank for the drive_pat pattern driver. CFG and PATSEL are
// double-buffered: software writes shadow copies, and the core only sees the
// active copies, which are loaded together on a commit. A commit comes from
// CTRL.COMMIT (while EN=0) or from sync_i at a pattern boundary (while EN=1
// and a shadow write is pending).
// Optional build macro WFG_DRIVE_PAT_REG_ERR_EN: unmapped accesses and STATUS
// writes end with wbs_err_o instead of wbs_ack_o.
module wfg_drive_pat_wb_regbank #(
    parameter int BUSW     = 32,
    parameter int CHANNELS = 32
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [BUSW/8-1:0]     wbs_sel_i,
    input  logic [BUSW-1:0]       wbs_dat_i,
    input  logic [BUSW-1:0]       wbs_adr_i,
    output logic                  wbs_ack_o,
    output logic                  wbs_err_o,
    output logic [BUSW-1:0]       wbs_dat_o,
    input  logic                  sync_i,
    output logic                  ctrl_en_o,
    output logic [7:0]            cfg_begin_o,
    output logic [7:0]            cfg_end_o,
    output logic [2*CHANNELS-1:0] patsel_o,
    output logic                  commit_o
);
    localparam int         NPAT      = CHANNELS / 16;
    localparam logic [5:0] PAT_FIRST = 6'd4;
    localparam logic [5:0] PAT_LAST  = 6'(4 + NPAT - 1);

    generate
        if (BUSW != 32) begin : g_bad_busw
            $error("wfg_drive_pat_wb_regbank: only BUSW=32 is supported");
        end
        if ((CHANNELS % 16) != 0 || CHANNELS < 16 || CHANNELS > 128) begin : g_bad_channels
            $error("wfg_drive_pat_wb_regbank: CHANNELS must be a multiple of 16 in 16..128");
        end
    endgenerate

    // Register state
    logic                  en;
    logic [15:0]           cfg_sh;
    logic [15:0]           cfg_act;
    logic [31:0]           pat_sh [NPAT];
    logic [2*CHANNELS-1:0] pat_act;
    logic                  pending;
    logic [7:0]            commit_cnt;
    logic                  commit_q;
    logic                  ack_q;
    logic                  resp_q;
    logic [31:0]           dat_q;

    // Decode
    logic [5:0]  word;
    logic        req, accept, bad, wr, rd_ok;
    logic        is_ctrl, is_cfg, is_status, is_pat;
    logic        shadow_wr, commit_a, commit_b, commit;
    logic [31:0] rdata;
    logic        unused_adr;

    // Handshake: a request is stb&cyc. It is accepted on the first edge where
    // it is seen and no response is currently being driven; exactly one of
    // ack/err is then high for the following cycle. Because a response blocks
    // acceptance on its own cycle, a request held across its response is not
    // taken twice and responses are always separated by an idle cycle.
    assign req        = wbs_stb_i & wbs_cyc_i;
    assign accept     = req & ~resp_q;
    assign word       = wbs_adr_i[7:2];
    assign unused_adr = &{1'b0, wbs_adr_i[BUSW-1:8], wbs_adr_i[1:0]};

    assign is_ctrl   = (word == 6'd0);
    assign is_cfg    = (word == 6'd1);
    assign is_status = (word == 6'd2);
    assign is_pat    = (word >= PAT_FIRST) && (word <= PAT_LAST);

`ifdef WFG_DRIVE_PAT_REG_ERR_EN
    logic err_q;
    assign bad    = ~(is_ctrl | is_cfg | is_status | is_pat) | (is_status & wbs_we_i);
    assign resp_q = ack_q | err_q;
    assign wbs_err_o = err_q;
`else
    assign bad    = 1'b0;
    assign resp_q = ack_q;
    assign wbs_err_o = 1'b0;
`endif

    assign wr    = accept & wbs_we_i & ~bad;
    assign rd_ok = accept & ~wbs_we_i & ~bad;

    assign shadow_wr = wr & (is_cfg | is_pat);
    assign commit_a  = wr & is_ctrl & wbs_sel_i[0] & ~wbs_dat_i[0] & wbs_dat_i[1];
    assign commit_b  = sync_i & en & pending;
    assign commit    = commit_a | commit_b;

    // Read mux: shadow values for CFG/PATSEL, undefined bits read 0
    always_comb begin
        rdata = '0;
        if (is_ctrl) begin
            rdata[0] = en;
        end else if (is_cfg) begin
            rdata[15:0] = cfg_sh;
        end else if (is_status) begin
            rdata[0]    = pending;
            rdata[15:8] = commit_cnt;
        end else begin
            for (int k = 0; k < NPAT; k++) begin
                if (word == (6'(k) + PAT_FIRST)) rdata = pat_sh[k];
            end
        end
    end

    // Register writes, commit (active <= pre-edge shadow), PENDING and counter
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en         <= 1'b0;
            cfg_sh     <= '0;
            cfg_act    <= '0;
            pat_act    <= '0;
            pending    <= 1'b0;
            commit_cnt <= '0;
            commit_q   <= 1'b0;
            for (int k = 0; k < NPAT; k++) pat_sh[k] <= '0;
        end else begin
            if (wr && is_ctrl && wbs_sel_i[0]) en <= wbs_dat_i[0];
            if (wr && is_cfg) begin
                if (wbs_sel_i[0]) cfg_sh[7:0]  <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) cfg_sh[15:8] <= wbs_dat_i[15:8];
            end
            for (int k = 0; k < NPAT; k++) begin
                if (wr && word == (6'(k) + PAT_FIRST)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wbs_sel_i[b]) pat_sh[k][8*b +: 8] <= wbs_dat_i[8*b +: 8];
                    end
                end
            end
            if (commit) begin
                cfg_act    <= cfg_sh;
                commit_cnt <= commit_cnt + 8'd1;
                for (int k = 0; k < NPAT; k++) pat_act[32*k +: 32] <= pat_sh[k];
            end
            if (shadow_wr)   pending <= 1'b1;
            else if (commit) pending <= 1'b0;
            commit_q <= commit;
        end
    end

    // Bus response: one-cycle ack (or err) with registered read data
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= accept & ~bad;
            dat_q <= rd_ok ? rdata : 32'h0;
        end
    end

`ifdef WFG_DRIVE_PAT_REG_ERR_EN
    // Error response for unmapped accesses and STATUS writes
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) err_q <= 1'b0;
        else          err_q <= accept & bad;
    end
`endif

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign ctrl_en_o   = en;
    assign cfg_begin_o = cfg_act[7:0];
    assign cfg_end_o   = cfg_act[15:8];
    assign patsel_o    = pat_act;
    assign commit_o    = commit_q;

endmodule

// File: tb/tb_wfg_drive_pat_wb_regbank.sv
// Testbench for wfg_drive_pat_wb_regbank: directed vector table, hand-written
// commit/sync sequences, counter wrap, randomized traffic against a
// transaction-level register model, and reset in the middle of a request.
module tb_wfg_drive_pat_wb_regbank;
  localparam int CHANNELS = 32;
  localparam int NPAT = CHANNELS / 16;
`ifdef WFG_DRIVE_PAT_REG_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                  wb_stb = 1'b0, wb_cyc = 1'b0, wb_we = 1'b0, sync = 1'b0;
  logic [3:0]            wb_sel = '0;
  logic [31:0]           wb_dat_w = '0, wb_adr = '0;
  logic                  wb_ack, wb_err, ctrl_en, commit;
  logic [31:0]           wb_dat_r;
  logic [7:0]            cfg_begin, cfg_end;
  logic [2*CHANNELS-1:0] patsel;

  wfg_drive_pat_wb_regbank #(.BUSW(32), .CHANNELS(CHANNELS)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(wb_stb), .wbs_cyc_i(wb_cyc), .wbs_we_i(wb_we),
    .wbs_sel_i(wb_sel), .wbs_dat_i(wb_dat_w), .wbs_adr_i(wb_adr),
    .wbs_ack_o(wb_ack), .wbs_err_o(wb_err), .wbs_dat_o(wb_dat_r),
    .sync_i(sync), .ctrl_en_o(ctrl_en), .cfg_begin_o(cfg_begin),
    .cfg_end_o(cfg_end), .patsel_o(patsel), .commit_o(commit)
  );

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  // register model
  logic        m_en, m_pending, m_resp_prev;
  logic [15:0] m_cfg_sh, m_cfg_act;
  logic [31:0] m_pat_sh [NPAT];
  logic [31:0] m_pat_act [NPAT];
  int          m_cnt;
  logic [31:0] last_rd;
  logic        last_ack, last_err;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_pending = 0; m_resp_prev = 0; m_cfg_sh = 0; m_cfg_act = 0; m_cnt = 0;
    for (int k = 0; k < NPAT; k++) begin m_pat_sh[k] = 0; m_pat_act[k] = 0; end
  endtask

  function automatic bit m_mapped(input logic [31:0] a);
    int w;
    w = int'(a[7:2]);
    return (w <= 2) || (w >= 4 && w < 4 + NPAT);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int w;
    w = int'(a[7:2]);
    if (w == 0) return {31'h0, m_en};
    if (w == 1) return {16'h0, m_cfg_sh};
    if (w == 2) return 32'(m_cnt * 256 + (m_pending ? 1 : 0));
    if (w >= 4 && w < 4 + NPAT) return m_pat_sh[w-4];
    return 32'h0;
  endfunction

  // One clock edge of the register map's rules: commits use shadow values
  // from before the edge, then the write lands, then PENDING is settled.
  task automatic model_edge(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic sy, output logic c);
    int w;
    logic shw;
    w = int'(a[7:2]);
    c = (sy && m_en && m_pending) || (wr && w == 0 && s[0] && d[1:0] == 2'b10);
    shw = wr && (w == 1 || (w >= 4 && w < 4 + NPAT));
    if (c) begin
      m_cfg_act = m_cfg_sh;
      for (int k = 0; k < NPAT; k++) m_pat_act[k] = m_pat_sh[k];
      m_cnt = (m_cnt + 1) % 256;
    end
    if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) begin
          if (w == 0 && b == 0) m_en = d[0];
          if (w == 1 && b < 2) m_cfg_sh[8*b +: 8] = d[8*b +: 8];
          if (w >= 4 && w < 4 + NPAT) m_pat_sh[w-4][8*b +: 8] = d[8*b +: 8];
        end
      end
    end
    if (shw) m_pending = 1'b1;
    else if (c) m_pending = 1'b0;
  endtask

  task automatic check_outputs(input logic e_commit);
    check("ctrl_en_o", ctrl_en, m_en);
    check("cfg_begin_o", cfg_begin, m_cfg_act[7:0]);
    check("cfg_end_o", cfg_end, m_cfg_act[15:8]);
    for (int k = 0; k < NPAT; k++) check($sformatf("patsel_o[%0d]", k), patsel[32*k +: 32], m_pat_act[k]);
    check("commit_o", commit, e_commit);
  endtask

  // driver: one clock cycle with the given bus/sync inputs, checked after the edge
  task automatic tick(input logic req, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic sy);
    logic acc, bad, e_ack, e_err, e_commit;
    logic [31:0] e_rd;
    @(negedge clk);
    wb_stb = req; wb_cyc = req; wb_we = w; wb_adr = a; wb_dat_w = d; wb_sel = s; sync = sy;
    @(posedge clk);
    acc = req && !m_resp_prev;
    bad = ERR_EN && (!m_mapped(a) || (a[7:2] == 6'd2 && w));
    e_ack = acc && !bad;
    e_err = acc && bad;
    e_rd = (e_ack && !w) ? m_read(a) : 32'h0;
    model_edge(e_ack && w, a, d, s, sy, e_commit);
    m_resp_prev = acc;
    #1;
    last_rd = wb_dat_r; last_ack = wb_ack; last_err = wb_err;
    check("ack", wb_ack, e_ack);
    check("err", wb_err, e_err);
    check("rdata", wb_dat_r, e_rd);
    check_outputs(e_commit);
  endtask

  // driver: full transfer; the request is held through its response cycle
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic sy, output logic [31:0] rd, output logic ak, output logic er);
    tick(1'b1, w, a, d, s, sy);
    rd = last_rd; ak = last_ack; er = last_err;
    tick(1'b1, w, a, d, s, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    wb_stb = 0; wb_cyc = 0; sync = 0; rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
    check("reset ack", wb_ack, 1'b0);
    check("reset err", wb_err, 1'b0);
    check("reset rdata", wb_dat_r, 32'h0);
    check_outputs(1'b0);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    logic [31:0] rd;
    logic ak, er;
    logic [5:0] word;
    logic [31:0] a;

    model_reset();
    do_reset();

    vecs.push_back('{1'b0, 32'h08, 32'h0,         4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h04, 32'h0000_1234, 4'h1, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h04, 32'h0,         4'hF, 32'h0000_0034, 1'b0});
    vecs.push_back('{1'b0, 32'h08, 32'h0,         4'hF, 32'h0000_0001, 1'b0});
    vecs.push_back('{1'b1, 32'h00, 32'h0000_0002, 4'h1, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h08, 32'h0,         4'hF, 32'h0000_0100, 1'b0});
    vecs.push_back('{1'b0, 32'h00, 32'h0,         4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h00, 32'h0000_0001, 4'h1, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h10, 32'hAAAA_5555, 4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h10, 32'h0,         4'hF, 32'hAAAA_5555, 1'b0});
    vecs.push_back('{1'b0, 32'h40, 32'h0,         4'hF, 32'h0000_0000, ERR_EN});
    vecs.push_back('{1'b1, 32'h08, 32'h0000_FFFF, 4'hF, 32'h0000_0000, ERR_EN});
    vecs.push_back('{1'b0, 32'h08, 32'h0,         4'hF, 32'h0000_0101, 1'b0});
    vecs.push_back('{1'b1, 32'h00, 32'h0000_0003, 4'h1, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h00, 32'h0,         4'hF, 32'h0000_0001, 1'b0});
    vecs.push_back('{1'b0, 32'h08, 32'h0,         4'hF, 32'h0000_0101, 1'b0});
    vecs.push_back('{1'b1, 32'h0C, 32'h0000_0055, 4'hF, 32'h0000_0000, ERR_EN});
    vecs.push_back('{1'b0, 32'h0C, 32'h0,         4'hF, 32'h0000_0000, ERR_EN});

    foreach (vecs[i]) begin
      bus(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, 1'b0, rd, ak, er);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d ack", i), ak, !vecs[i].exp_err);
      check($sformatf("vec%0d err", i), er, vecs[i].exp_err);
    end
    check("cfg_begin after ctrl commit", cfg_begin, 8'h34);

    // sync commit with EN=1 and PENDING=1, then a sync with nothing pending
    tick(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    check("sync commit patsel0", patsel[31:0], 32'hAAAA_5555);
    check("sync commit pulse", commit, 1'b1);
    bus(1'b0, 32'h08, 32'h0, 4'hF, 1'b0, rd, ak, er);
    check("status after sync", rd, 32'h0000_0200);
    tick(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    check("idle sync no pulse", commit, 1'b0);
    bus(1'b0, 32'h08, 32'h0, 4'hF, 1'b0, rd, ak, er);
    check("status after idle sync", rd, 32'h0000_0200);

    // sync coincident with a PATSEL0 write: commit takes the old shadow
    bus(1'b1, 32'h14, 32'h0000_0001, 4'hF, 1'b0, rd, ak, er);
    tick(1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, 1'b1);
    check("coincident patsel0", patsel[31:0], 32'hAAAA_5555);
    check("coincident patsel1", patsel[63:32], 32'h0000_0001);
    check("coincident pulse", commit, 1'b1);
    tick(1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, 1'b0);
    bus(1'b0, 32'h08, 32'h0, 4'hF, 1'b0, rd, ak, er);
    check("coincident status", rd, 32'h0000_0301);
    tick(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    check("next sync patsel0", patsel[31:0], 32'hFFFF_FFFF);

    // COMMIT_CNT wrap 255 -> 0 via CTRL.COMMIT with EN=0
    bus(1'b1, 32'h00, 32'h2, 4'h1, 1'b0, rd, ak, er);
    for (int i = 0; i < 300 && m_cnt != 255; i++) bus(1'b1, 32'h00, 32'h2, 4'h1, 1'b0, rd, ak, er);
    bus(1'b0, 32'h08, 32'h0, 4'hF, 1'b0, rd, ak, er);
    check("commit_cnt at 255", rd[15:8], 8'hFF);
    bus(1'b1, 32'h00, 32'h2, 4'h1, 1'b0, rd, ak, er);
    bus(1'b0, 32'h08, 32'h0, 4'hF, 1'b0, rd, ak, er);
    check("commit_cnt wrapped", rd[15:8], 8'h00);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        tick(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      end else begin
        case ($urandom_range(0, 7))
          0: word = 6'd0;
          1: word = 6'd1;
          2: word = 6'd2;
          3: word = 6'd3;
          4: word = 6'd4;
          5: word = 6'(4 + NPAT - 1);
          6: word = 6'd16;
          default: word = 6'($urandom_range(0, 63));
        endcase
        a = ($urandom & 32'hFFFF_FF03) | {24'h0, word, 2'b00};
        bus(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0), rd, ak, er);
      end
    end

    // reset in the middle of a request: response dropped, state cleared
    bus(1'b1, 32'h00, 32'h1, 4'h1, 1'b0, rd, ak, er);
    @(negedge clk);
    wb_stb = 1; wb_cyc = 1; wb_we = 1; wb_adr = 32'h04; wb_dat_w = 32'hFFFF; wb_sel = 4'hF; sync = 0;
    #2 rst = 1;
    @(posedge clk);
    #1;
    model_reset();
    check("mid-reset ack", wb_ack, 1'b0);
    check("mid-reset err", wb_err, 1'b0);
    check_outputs(1'b0);
    @(negedge clk);
    wb_stb = 0; wb_cyc = 0; rst = 0;
    bus(1'b0, 32'h04, 32'h0, 4'hF, 1'b0, rd, ak, er);
    check("cfg after mid-reset", rd, 32'h0);
    bus(1'b0, 32'h08, 32'h0, 4'hF, 1'b0, rd, ak, er);
    check("status after mid-reset", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wfg_drive_pat_wb_regbank.md
Name: wfg_drive_pat_wb_regbank

Overview:
- Parametrised Wishbone register bank for the drive_pat pattern driver.
- Supports N channels with 2 pattern-select bits each, byte-lane writes, and double-buffered (shadow/active) configuration committed atomically.
- Sits between the Wishbone interconnect and the drive_pat core; the core sees only active registers and provides a sync strobe at pattern boundaries.

Parameters:
- BUSW, 32, Wishbone data/address width; only 32 is supported, elaboration error otherwise.
- CHANNELS, 32, pattern channels; multiple of 16, range 16..128.
- NPAT (localparam), CHANNELS/16, number of PATSEL words (16 channels × 2 bits per word).

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  asynchronous, active-high reset
- wbs_stb_i  in  1  strobe
- wbs_cyc_i  in  1  cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  BUSW/8  byte-lane select
- wbs_dat_i  in  BUSW  write data
- wbs_adr_i  in  BUSW  byte address; only [7:2] decoded
- wbs_ack_o  out  1  normal termination
- wbs_err_o  out  1  error termination (see Optional Feature)
- wbs_dat_o  out  BUSW  read data
- sync_i  in  1  core pattern-boundary strobe
- ctrl_en_o  out  1  active CTRL.EN
- cfg_begin_o  out  8  active CFG.BEGIN
- cfg_end_o  out  8  active CFG.END
- patsel_o  out  2*CHANNELS  active PATSEL; channel c uses bits [2c+1:2c]
- commit_o  out  1  one-cycle pulse after an active-register update

Behaviour:
- Register map (byte offsets):
  - 0x00 CTRL: bit0 EN, direct, not shadowed; bit1 COMMIT, write-only, reads 0.
  - 0x04 CFG: [7:0] BEGIN, [15:8] END; shadowed.
  - 0x08 STATUS, read-only: bit0 PENDING; [15:8] COMMIT_CNT.
  - 0x10+4k PATSEL k, k=0..NPAT-1; shadowed.
  - All other offsets are unmapped.
- Reset: asynchronous; all shadow, active, PENDING and COMMIT_CNT cleared to 0; all outputs 0.
- Handshake:
  - A request is stb&cyc.
  - Exactly one of ack/err pulses for one cycle, one cycle after the request is first seen.
  - The response is always followed by at least one idle cycle; no back-to-back responses.
  - A request held high across its own response is not accepted twice.
- Writes:
  - Take effect on the same edge that asserts ack.
  - Byte lanes with sel=0 are unchanged; bits undefined in the map are ignored.
  - Any accepted write to CFG or PATSEL (any sel value) sets PENDING.
- Reads:
  - wbs_dat_o is registered and valid in the ack cycle; 0 in all other cycles.
  - Reads return shadow values for CFG/PATSEL; undefined bits read 0.
- Commit (active <= shadow for CFG and all PATSEL words):
  - (a) CTRL write with new bit0=0 and bit1=1 on sel[0] → commit on the accept edge, regardless of PENDING.
  - (b) sync_i=1 while active EN=1 and PENDING=1 → commit on that edge.
  - CTRL.COMMIT written with EN=1 is ignored.
- Each commit:
  - Clears PENDING, unless a shadow write is accepted on the same edge; then PENDING stays 1 and the commit uses the pre-write shadow value.
  - Increments COMMIT_CNT modulo 256 (255→0).
  - Drives commit_o=1 in the following cycle.
- Reset mid-transaction: the response is dropped; the master re-issues.

Optional Feature:
- Macro: WFG_DRIVE_PAT_REG_ERR_EN.
- Defined:
  - An unmapped access or a write to STATUS terminates with wbs_err_o instead of ack.
  - No state changes; wbs_dat_o=0.
- Undefined:
  - wbs_err_o is tied 0.
  - Unmapped accesses and STATUS writes are acked with no state change; unmapped reads return 0.

Test Plan:
- Reset, then read 0x08 → ack after 1 cycle, data 0x0; all outputs 0.
- Write 0x04=0x0000_1234 with sel=4'b0001 → read 0x04 returns 0x0000_0034; PENDING=1; cfg_begin_o stays 0.
- With EN=0, write 0x00=0x2 → cfg_begin_o=0x34 on the accept edge; commit_o high the next cycle; STATUS=0x0000_0100.
- With EN=1, write PATSEL0=0xAAAA_5555, pulse sync_i → patsel_o[31:0]=0xAAAA_5555; a second sync_i with PENDING=0 → no commit, COMMIT_CNT unchanged.
- sync_i coincident with an accepted PATSEL0 write of 0xFFFF_FFFF → active gets the old shadow value; PENDING=1; the next sync_i applies 0xFFFF_FFFF.
- Read 0x40 with CHANNELS=32 → err (macro defined) or ack with data 0 (macro undefined); no state change in either case.
